id_ctrl_sequencer: RTL and testbench

Decode-stage control sequencer between the combinational main-control decoder and the ID/EX boundary. It registers the decoded control word into EX and issues bubbles on flush or hazard. It also tracks multi-cycle MULT/MULTU/DIV/DIVU operations with a parametrised busy counter and stalls ID for dependent MFHI/MFLO and structural conflicts. It adds the HI/LO multiply/divide support and stall/flush handling that the current decode path lacks.

---
 rtl/id_ctrl_sequencer.sv | 160 ++++++++++++++++
 tb/tb_id_ctrl_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ctrl_sequencer.sv
// id_ctrl_sequencer: registers the decoded control word into the ID/EX
// boundary, inserts bubbles on flush or hazard, and sequences the
// multi-cycle HI/LO multiply/divide unit. While a MULT/MULTU/DIV/DIVU is in
// flight, any further multiply/divide or MFHI/MFLO in ID is held back.
// Unrelated instructions keep flowing through.
module id_ctrl_sequencer #(
    parameter int                CTRL_W     = 20,
    parameter logic [CTRL_W-1:0] NOP_WORD   = {CTRL_W{1'b0}},
    parameter int                MUL_CYCLES = 4,
    parameter int                DIV_CYCLES = 32,
    parameter int                CNT_W      = $clog2(((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES) + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [5:0]        i_op,
    input  logic [5:0]        i_funct,
    input  logic [CTRL_W-1:0] i_ctrl_regs,
    input  logic              i_flush,
    input  logic              i_ex_stall,
    output logic [CTRL_W-1:0] o_ctrl_regs,
    output logic              o_valid,
    output logic              o_md_start,
    output logic [1:0]        o_md_op,
    output logic              o_md_busy,
    output logic              o_md_done,
    output logic              o_stall_id
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic                valid_q, valid_d;
    logic                start_q, start_d;
    logic [1:0]          md_op_q, md_op_d;

    logic                is_muldiv_s;
    logic                is_hilo_s;
    logic                hazard_s;
    logic                load_s;
    logic                issue_s;

    // Classify the ID instruction as a multiply/divide or a HI/LO read.
    always_comb begin
        is_muldiv_s = 1'b0;
        is_hilo_s   = 1'b0;
        if (i_op == OP_SPECIAL) begin
            case (i_funct)
                FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: is_muldiv_s = 1'b1;
                FN_MFHI, FN_MFLO:                   is_hilo_s   = 1'b1;
                default: begin
                    is_muldiv_s = 1'b0;
                    is_hilo_s   = 1'b0;
                end
            endcase
        end else begin
            is_muldiv_s = 1'b0;
            is_hilo_s   = 1'b0;
        end
    end

    // Hazard, stall and load qualification; a flush wins over a hazard stall.
    always_comb begin
        hazard_s   = i_valid & (is_muldiv_s | is_hilo_s) & (state_q == ST_BUSY);
        o_stall_id = i_ex_stall | (hazard_s & ~i_flush);
        load_s     = ~i_ex_stall & i_valid & ~i_flush & ~hazard_s;
        issue_s    = load_s & is_muldiv_s;
    end

    // Next-state for the ID/EX register and the HI/LO sequencing FSM.
    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        start_d = 1'b0;
        md_op_d = md_op_q;
        state_d = state_q;
        cnt_d   = cnt_q;

        if (i_ex_stall) begin
            ctrl_d  = ctrl_q;
            valid_d = valid_q;
        end else if (load_s) begin
            ctrl_d  = i_ctrl_regs;
            valid_d = 1'b1;
        end else begin
            ctrl_d  = NOP_WORD;
            valid_d = 1'b0;
        end

        // The busy counter runs independently of stalls and flushes.
        case (state_q)
            ST_IDLE: begin
                if (issue_s) begin
                    start_d = 1'b1;
                    md_op_d = i_funct[1:0];
                    cnt_d   = i_funct[1] ? DIV_LOAD : MUL_LOAD;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            ctrl_q  <= NOP_WORD;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            md_op_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            start_q <= start_d;
            md_op_q <= md_op_d;
        end
    end

    assign o_ctrl_regs = ctrl_q;
    assign o_valid     = valid_q;
    assign o_md_start  = start_q;
    assign o_md_op     = md_op_q;
    assign o_md_busy   = (state_q == ST_BUSY);
    assign o_md_done   = (state_q == ST_BUSY) & (cnt_q == CNT_ZERO);

endmodule

// File: tb/tb_id_ctrl_sequencer.sv
// Bench for id_ctrl_sequencer: a default build and a short-latency build
// (MUL_CYCLES=1, DIV_CYCLES=3) share one input stream and are both compared
// every cycle against a remaining-cycles reference model.
module tb_id_ctrl_sequencer;

    localparam int CW = 20;

    logic          clk;
    logic          rst_n;
    logic          r_valid;
    logic [5:0]    r_op;
    logic [5:0]    r_fn;
    logic [CW-1:0] r_ctrl;
    logic          r_flush;
    logic          r_exst;

    logic [1:0][CW-1:0] o_ctrl_w;
    logic [1:0]         o_valid_w;
    logic [1:0]         o_start_w;
    logic [1:0][1:0]    o_op_w;
    logic [1:0]         o_busy_w;
    logic [1:0]         o_done_w;
    logic [1:0]         o_stall_w;

    int checks   = 0;
    int failures = 0;

    // Reference model state, one slot per DUT.
    int            mulc [2] = '{4, 1};
    int            divc [2] = '{32, 3};
    int            m_rem   [2];
    logic [CW-1:0] m_ctrl  [2];
    logic          m_valid [2];
    logic          m_start [2];
    logic [1:0]    m_op    [2];
    logic          last_stall [2];

    id_ctrl_sequencer #(.CTRL_W(CW)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_valid(r_valid), .i_op(r_op),
        .i_funct(r_fn), .i_ctrl_regs(r_ctrl), .i_flush(r_flush),
        .i_ex_stall(r_exst), .o_ctrl_regs(o_ctrl_w[0]), .o_valid(o_valid_w[0]),
        .o_md_start(o_start_w[0]), .o_md_op(o_op_w[0]), .o_md_busy(o_busy_w[0]),
        .o_md_done(o_done_w[0]), .o_stall_id(o_stall_w[0])
    );

    id_ctrl_sequencer #(.CTRL_W(CW), .MUL_CYCLES(1), .DIV_CYCLES(3)) dut1 (
        .i_clk(clk), .i_reset(rst_n), .i_valid(r_valid), .i_op(r_op),
        .i_funct(r_fn), .i_ctrl_regs(r_ctrl), .i_flush(r_flush),
        .i_ex_stall(r_exst), .o_ctrl_regs(o_ctrl_w[1]), .o_valid(o_valid_w[1]),
        .o_md_start(o_start_w[1]), .o_md_op(o_op_w[1]), .o_md_busy(o_busy_w[1]),
        .o_md_done(o_done_w[1]), .o_stall_id(o_stall_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_md(input logic [5:0] op, input logic [5:0] fn);
        return (op == 6'd0) && (fn inside {6'h18, 6'h19, 6'h1A, 6'h1B});
    endfunction

    function automatic logic is_hl(input logic [5:0] op, input logic [5:0] fn);
        return (op == 6'd0) && (fn inside {6'h10, 6'h12});
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_rem[k] = 0; m_ctrl[k] = '0; m_valid[k] = 1'b0;
            m_start[k] = 1'b0; m_op[k] = 2'b00;
        end
    endtask

    function automatic logic model_hazard(input int k);
        return r_valid && (is_md(r_op, r_fn) || is_hl(r_op, r_fn)) && (m_rem[k] > 0);
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic haz;
            haz = model_hazard(k);
            m_start[k] = 1'b0;
            if (m_rem[k] > 0) m_rem[k] = m_rem[k] - 1;
            if (r_exst) begin
                // hold everything
            end else if (r_flush || !r_valid || haz) begin
                m_ctrl[k] = '0; m_valid[k] = 1'b0;
            end else begin
                m_ctrl[k] = r_ctrl; m_valid[k] = 1'b1;
                if (is_md(r_op, r_fn)) begin
                    m_start[k] = 1'b1;
                    m_op[k]    = r_fn[1:0];
                    m_rem[k]   = r_fn[1] ? divc[k] : mulc[k];
                end
            end
        end
    endtask

    task automatic check_outputs(input string where);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s.d%0d.ctrl", where, k), 32'(o_ctrl_w[k]), 32'(m_ctrl[k]));
            chk($sformatf("%s.d%0d.valid", where, k), 32'(o_valid_w[k]), 32'(m_valid[k]));
            chk($sformatf("%s.d%0d.start", where, k), 32'(o_start_w[k]), 32'(m_start[k]));
            chk($sformatf("%s.d%0d.op", where, k), 32'(o_op_w[k]), 32'(m_op[k]));
            chk($sformatf("%s.d%0d.busy", where, k), 32'(o_busy_w[k]), 32'(m_rem[k] > 0));
            chk($sformatf("%s.d%0d.done", where, k), 32'(o_done_w[k]), 32'(m_rem[k] == 1));
        end
    endtask

    // One cycle: drive at negedge, check, clock, update model.
    task automatic step(input string tag, input logic v, input logic [5:0] op,
                        input logic [5:0] fn, input logic [CW-1:0] c,
                        input logic fl, input logic st);
        @(negedge clk);
        r_valid = v; r_op = op; r_fn = fn; r_ctrl = c; r_flush = fl; r_exst = st;
        #1;
        for (int k = 0; k < 2; k++) begin
            logic es;
            es = r_exst || (model_hazard(k) && !r_flush);
            last_stall[k] = o_stall_w[k];
            chk($sformatf("%s.d%0d.stall", tag, k), 32'(o_stall_w[k]), 32'(es));
        end
        check_outputs(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("idle", 1'b0, 6'h00, 6'h00, '0, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        r_valid = 1'b0; r_op = '0; r_fn = '0; r_ctrl = '0; r_flush = 1'b0; r_exst = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // MULT then MFLO held in ID.
        step("mult", 1'b1, 6'h00, 6'h18, 20'h11111, 1'b0, 1'b0);
        chk("mult_start", 32'(o_start_w[0]), 32'd1);
        chk("mult_op", 32'(o_op_w[0]), 32'd0);
        n = 0;
        begin
            int n1;
            n1 = 0;
            for (int i = 0; i < 8; i++) begin
                step("mflo", 1'b1, 6'h00, 6'h12, 20'h22222, 1'b0, 1'b0);
                if (last_stall[0]) n++;
                if (last_stall[1]) n1++;
            end
            chk("mflo_stall_cycles", 32'(n), 32'd4);
            chk("mflo_stall_cycles_n1", 32'(n1), 32'd1);
        end
        idle(2);

        // DIVU with independent ADDI traffic, then a dependent DIV.
        step("divu", 1'b1, 6'h00, 6'h1B, 20'h33333, 1'b0, 1'b0);
        chk("divu_op", 32'(o_op_w[0]), 32'd3);
        for (int i = 0; i < 5; i++) step("addi", 1'b1, 6'h08, 6'h00, CW'(20'h40000 + i), 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step("div_wait", 1'b1, 6'h00, 6'h1A, 20'h44444, 1'b0, 1'b0);
            if (!last_stall[0]) break;
            n++;
        end
        chk("div_stall_cycles", 32'(n), 32'd27);
        idle(40);

        // EX stall hold, with a MULT waiting behind it.
        step("ld5a", 1'b1, 6'h08, 6'h00, 20'h5A5A5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("exst", 1'b1, 6'h00, 6'h18, 20'h0F0F0, 1'b0, 1'b1);
            chk("exst_hold", 32'(o_ctrl_w[0]), 32'h5A5A5);
            chk("exst_nostart", 32'(o_start_w[0]), 32'd0);
        end
        step("exst_rel", 1'b1, 6'h00, 6'h18, 20'h0F0F0, 1'b0, 1'b0);
        chk("exst_rel_start", 32'(o_start_w[0]), 32'd1);

        // Flush against a hazard, then flush on a MULT.
        step("mfhi_fl", 1'b1, 6'h00, 6'h10, 20'h12345, 1'b1, 1'b0);
        chk("mfhi_fl_busy", 32'(o_busy_w[0]), 32'd1);
        idle(6);
        step("mult_fl", 1'b1, 6'h00, 6'h18, 20'h54321, 1'b1, 1'b0);
        chk("mult_fl_busy", 32'(o_busy_w[0]), 32'd0);
        chk("mult_fl_start", 32'(o_start_w[0]), 32'd0);

        // Reset mid-DIV at busy cycle 10.
        step("div_rst", 1'b1, 6'h00, 6'h1A, 20'h77777, 1'b0, 1'b0);
        idle(9);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        step("add", 1'b1, 6'h00, 6'h20, 20'h0ADD0, 1'b0, 1'b0);
        chk("add_valid", 32'(o_valid_w[0]), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            int cls;
            logic [5:0] op, fn;
            cls = int'($urandom_range(0, 9));
            if (cls < 2) begin
                op = 6'h00; fn = 6'(6'h18 + 6'($urandom_range(0, 3)));
            end else if (cls == 2) begin
                op = 6'h00; fn = ($urandom_range(0, 1) == 0) ? 6'h10 : 6'h12;
            end else if (cls < 6) begin
                op = 6'h00; fn = ($urandom_range(0, 1) == 0) ? 6'h20 : 6'h21;
            end else begin
                op = 6'($urandom_range(1, 63)); fn = 6'($urandom_range(0, 63));
            end
            step("rnd", ($urandom_range(0, 9) != 0), op, fn, CW'($urandom),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
